uart_pkt_parser: RTL

UART_PKT_PARSER -- requirements
Module: uart_pkt_parser

---
 rtl/uart_pkt_parser.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_pkt_parser.sv
// rtl/uart_pkt_parser.sv - store-and-forward parser for SYNC/LEN/payload/CSUM byte packets
module uart_pkt_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_frame,
  input  logic       rx_done,
  input  logic       frame_error,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam int LW    = $clog2(MAX_LEN + 1);
  localparam int DEPTH = 1 << LW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CSUM    = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;

  logic [2:0]    state;
  logic [LW-1:0] len;
  logic [LW-1:0] idx;
  logic [LW-1:0] idx_nxt;
  logic [7:0]    csum;
  logic [TW-1:0] tcnt;
  logic [7:0]    buffer [DEPTH];
  logic          in_pkt;
  logic          timeout;

  assign idx_nxt = idx + LW'(1);
  assign in_pkt  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
  // A byte arriving in the same cycle always beats the timeout.
  assign timeout = in_pkt && !rx_done && (tcnt == TW'(TIMEOUT_CYC - 1));

  // Payload storage is not reset; it is only read after being fully written.
  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && rx_done && !frame_error)
      buffer[idx] <= rx_frame;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_HUNT;
      len      <= '0;
      idx      <= '0;
      csum     <= '0;
      tcnt     <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= 2'd0;
      overrun  <= 1'b0;
    end else begin
      pkt_ok  <= 1'b0;
      pkt_err <= 1'b0;
      overrun <= 1'b0;

      if (in_pkt && !rx_done && !timeout)
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;

      if (timeout) begin
        pkt_err  <= 1'b1;
        err_code <= 2'd3;
        state    <= S_HUNT;
      end else begin
        case (state)
          S_HUNT: begin
            if (rx_done && !frame_error && rx_frame == SYNC_BYTE)
              state <= S_LEN;
          end
          S_LEN, S_PAYLOAD, S_CSUM: begin
            if (rx_done) begin
              if (frame_error) begin
                pkt_err  <= 1'b1;
                err_code <= 2'd2;
                state    <= S_HUNT;
              end else if (state == S_LEN) begin
                if (rx_frame == 8'd0 || rx_frame > 8'(MAX_LEN)) begin
                  pkt_err  <= 1'b1;
                  err_code <= 2'd1;
                  state    <= S_HUNT;
                end else begin
                  len   <= rx_frame[LW-1:0];
                  csum  <= rx_frame;
                  idx   <= '0;
                  state <= S_PAYLOAD;
                end
              end else if (state == S_PAYLOAD) begin
                csum <= csum ^ rx_frame;
                idx  <= idx_nxt;
                if (idx_nxt == len)
                  state <= S_CSUM;
              end else if (rx_frame == csum) begin
                pkt_ok  <= 1'b1;
                m_valid <= 1'b1;
                m_data  <= buffer[0];
                m_last  <= (len == LW'(1));
                idx     <= '0;
                state   <= S_OUTPUT;
              end else begin
                pkt_err  <= 1'b1;
                err_code <= 2'd0;
                state    <= S_HUNT;
              end
            end
          end
          S_OUTPUT: begin
            overrun <= rx_done;
            if (m_valid && m_ready) begin
              if (m_last) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                state   <= S_HUNT;
              end else begin
                idx    <= idx_nxt;
                m_data <= buffer[idx_nxt];
                m_last <= (idx_nxt == len - LW'(1));
              end
            end
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

endmodule
